// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush control logic.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic hazard;
  } ctrl_t;

  // Held while rst is asserted: nothing advances and both pipeline registers load bubbles.
  localparam ctrl_t CTRL_RESET    = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                      id_ex_flush: 1'b1, hazard: 1'b0};
  localparam ctrl_t CTRL_BRANCH   = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                      id_ex_flush: 1'b1, hazard: 1'b0};
  localparam ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                      id_ex_flush: 1'b1, hazard: 1'b1};
  localparam ctrl_t CTRL_FETCH    = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                      id_ex_flush: 1'b1, hazard: 1'b0};
  localparam ctrl_t CTRL_NORMAL   = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                      id_ex_flush: 1'b0, hazard: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear and asynchronous reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the IF/ID and ID/EX registers: load-use bubbles,
// taken-branch squash, fetch stall, plus saturating performance counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs_addr_i,
  input  logic [4:0]       id_rt_addr_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_addr_i,
  input  logic             branch_taken_i,
  input  logic             fetch_stall_i,
  input  logic             clr_cnt_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             hazard_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_events_o
);

  localparam logic [2:0] BUB_LOAD = 3'(LOAD_BUBBLES - 1);

  hz_state_t  state, state_next;
  logic [2:0] bub_cnt, bub_cnt_next;
  logic       lu_hit;
  ctrl_t      ctrl;

  assign lu_hit = id_valid_i && ex_memread_i && (ex_rt_addr_i != REG_ZERO) &&
                  ((ex_rt_addr_i == id_rs_addr_i) ||
                   (id_uses_rt_i && (ex_rt_addr_i == id_rt_addr_i)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      bub_cnt <= 3'd0;
    end else begin
      state   <= state_next;
      bub_cnt <= bub_cnt_next;
    end
  end

  // A taken branch squashes the stalled instruction, so it abandons any pending bubbles.
  always_comb begin
    state_next   = state;
    bub_cnt_next = bub_cnt;
    if (branch_taken_i) begin
      state_next   = RUN;
      bub_cnt_next = 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (lu_hit && (LOAD_BUBBLES > 1)) begin
            state_next   = LU_STALL;
            bub_cnt_next = BUB_LOAD;
          end
        end
        LU_STALL: begin
          bub_cnt_next = bub_cnt - 3'd1;
          if (bub_cnt == 3'd1) state_next = RUN;
        end
        default: begin
          state_next   = RUN;
          bub_cnt_next = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    ctrl = CTRL_NORMAL;
    if (rst)                                        ctrl = CTRL_RESET;
    else if (branch_taken_i)                        ctrl = CTRL_BRANCH;
    else if ((state == LU_STALL) || lu_hit)         ctrl = CTRL_LOAD_USE;
    else if (fetch_stall_i)                         ctrl = CTRL_FETCH;
  end

  assign pc_write_o    = ctrl.pc_write;
  assign if_id_write_o = ctrl.if_id_write;
  assign if_id_flush_o = ctrl.if_id_flush;
  assign id_ex_flush_o = ctrl.id_ex_flush;
  assign hazard_o      = ctrl.hazard;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!ctrl.pc_write && !rst),
    .clr   (clr_cnt_i),
    .count (stall_cycles_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (branch_taken_i),
    .clr   (clr_cnt_i),
    .count (flush_events_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (3 bubbles / 4-bit counters and 1 bubble /
// 16-bit counters) share stimulus and are checked against a bubble-count model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_uses_rt, ex_memread, branch_taken, fetch_stall, clr_cnt;
  logic [4:0] id_rs, id_rt, ex_rt;

  logic        a_pc, a_ifw, a_iff, a_idf, a_hz;
  logic [3:0]  a_sc, a_fe;
  logic        b_pc, b_ifw, b_iff, b_idf, b_hz;
  logic [15:0] b_sc, b_fe;

  logic [4:0]  ctl [2];
  logic [15:0] sc  [2];
  logic [15:0] fe  [2];

  int tests  = 0;
  int errors = 0;

  int lb   [2] = '{3, 1};
  int cmax [2] = '{15, 65535};
  int left [2];
  int m_sc [2];
  int m_fe [2];

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_BUBBLES(3), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rs_addr_i(id_rs), .id_rt_addr_i(id_rt),
    .id_uses_rt_i(id_uses_rt), .ex_memread_i(ex_memread), .ex_rt_addr_i(ex_rt),
    .branch_taken_i(branch_taken), .fetch_stall_i(fetch_stall), .clr_cnt_i(clr_cnt),
    .pc_write_o(a_pc), .if_id_write_o(a_ifw), .if_id_flush_o(a_iff), .id_ex_flush_o(a_idf),
    .hazard_o(a_hz), .stall_cycles_o(a_sc), .flush_events_o(a_fe));

  hazard_ctrl #(.LOAD_BUBBLES(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rs_addr_i(id_rs), .id_rt_addr_i(id_rt),
    .id_uses_rt_i(id_uses_rt), .ex_memread_i(ex_memread), .ex_rt_addr_i(ex_rt),
    .branch_taken_i(branch_taken), .fetch_stall_i(fetch_stall), .clr_cnt_i(clr_cnt),
    .pc_write_o(b_pc), .if_id_write_o(b_ifw), .if_id_flush_o(b_iff), .id_ex_flush_o(b_idf),
    .hazard_o(b_hz), .stall_cycles_o(b_sc), .flush_events_o(b_fe));

  assign ctl[0] = {a_pc, a_ifw, a_iff, a_idf, a_hz};
  assign ctl[1] = {b_pc, b_ifw, b_iff, b_idf, b_hz};
  assign sc[0]  = {12'd0, a_sc};
  assign sc[1]  = b_sc;
  assign fe[0]  = {12'd0, a_fe};
  assign fe[1]  = b_fe;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit model_lu();
    return id_valid && ex_memread && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

  // Expected {pc_write, if_id_write, if_id_flush, id_ex_flush, hazard}.
  function automatic logic [4:0] model_ctrl(int i);
    if (rst)                         return 5'b00110;
    if (branch_taken)                return 5'b11110;
    if (left[i] > 0 || model_lu())   return 5'b00011;
    if (fetch_stall)                 return 5'b00010;
    return 5'b11000;
  endfunction

  task automatic step();
    logic [4:0] e [2];
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        left[i] = 0; m_sc[i] = 0; m_fe[i] = 0;
      end
      e[i] = model_ctrl(i);
      chk($sformatf("ctrl[%0d]", i), 32'(ctl[i]), 32'(e[i]));
      chk($sformatf("stall_cycles[%0d]", i), 32'(sc[i]), m_sc[i]);
      chk($sformatf("flush_events[%0d]", i), 32'(fe[i]), m_fe[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        if (branch_taken)    left[i] = 0;
        else if (left[i] > 0) left[i] = left[i] - 1;
        else if (model_lu()) left[i] = lb[i] - 1;
        if (clr_cnt) begin
          m_sc[i] = 0; m_fe[i] = 0;
        end else begin
          if (!e[i][4] && m_sc[i] < cmax[i]) m_sc[i]++;
          if (branch_taken && m_fe[i] < cmax[i]) m_fe[i]++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drv(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit ut,
                     input bit mr, input bit [4:0] ert, input bit br, input bit fs,
                     input bit clr);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ut;
    ex_memread = mr; ex_rt = ert; branch_taken = br; fetch_stall = fs; clr_cnt = clr;
    step();
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_memread = 0; ex_rt = 0; branch_taken = 0; fetch_stall = 0; clr_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      left[i] = 0; m_sc[i] = 0; m_fe[i] = 0;
    end
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    for (int c = 0; c < 10; c++) drv(1, 5'd3, 5'd4, 1, 0, 5'd0, 0, 0, 0);

    // Load-use on rs, memread clears once the bubble reaches EX.
    drv(1, 5'd2, 5'd5, 1, 1, 5'd2, 0, 0, 0);
    for (int c = 0; c < 4; c++) drv(1, 5'd2, 5'd5, 1, 0, 5'd0, 0, 0, 0);
    drv(1, 5'd1, 5'd6, 1, 1, 5'd0, 0, 0, 0);
    drv(1, 5'd1, 5'd6, 0, 1, 5'd6, 0, 0, 0);
    drv(1, 5'd1, 5'd6, 1, 1, 5'd6, 0, 0, 0);
    drv(1, 5'd1, 5'd6, 1, 0, 5'd0, 0, 0, 0);
    drv(1, 5'd1, 5'd6, 1, 0, 5'd0, 0, 0, 0);
    drv(1, 5'd1, 5'd6, 1, 0, 5'd0, 0, 0, 0);

    // Branch in the second cycle of a stall.
    drv(1, 5'd7, 5'd0, 0, 1, 5'd7, 0, 0, 0);
    drv(1, 5'd7, 5'd0, 0, 0, 5'd0, 1, 0, 0);
    drv(1, 5'd7, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    drv(1, 5'd7, 5'd0, 0, 0, 5'd0, 0, 0, 0);

    for (int c = 0; c < 4; c++) drv(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0);
    drv(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 1);
    drv(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0);

    for (int c = 0; c < 20; c++) drv(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0);
    drv(1, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, 0);

    // Asynchronous reset landing inside a stall.
    drv(1, 5'd9, 5'd0, 0, 1, 5'd9, 0, 0, 0);
    drv(1, 5'd9, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pc_write", 32'(a_pc), 0);
    chk("async_rst_flush", 32'({a_iff, a_idf}), 32'b11);
    chk("async_rst_cnt", 32'(a_sc), 0);
    @(negedge clk);
    step();
    rst = 1'b0;
    drv(1, 5'd9, 5'd0, 0, 0, 5'd0, 0, 0, 0);

    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      drv($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
          $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 29) == 0);
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Drives the stall/flush side of the IF/ID and ID/EX registers: pc_write_o, if_id_write_o, if_id_flush_o, id_ex_flush_o.
- Detects load-use hazards and inserts LOAD_BUBBLES bubbles via an internal FSM and counter.
- Squashes wrong-path instructions on a taken branch, honours an external fetch stall, and keeps saturating performance counters.

Parameters:
- LOAD_BUBBLES, 1, number of bubble cycles inserted per load-use hazard (legal range 1..7).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- id_valid_i  input  1  ID stage holds a real instruction
- id_rs_addr_i  input  5  rs of the instruction in ID
- id_rt_addr_i  input  5  rt of the instruction in ID
- id_uses_rt_i  input  1  ID instruction reads rt as a source (R-type, sw, beq)
- ex_memread_i  input  1  MemRead of the instruction in EX (ID/EX output)
- ex_rt_addr_i  input  5  rt address of the instruction in EX (ID/EX output)
- branch_taken_i  input  1  taken branch/jump resolved this cycle; PC loads the target
- fetch_stall_i  input  1  instruction memory not ready
- clr_cnt_i  input  1  synchronous clear of the performance counters
- pc_write_o  output  1  PC update enable
- if_id_write_o  output  1  IF/ID update enable
- if_id_flush_o  output  1  IF/ID load NOP
- id_ex_flush_o  output  1  ID/EX load bubble (all controls zero)
- hazard_o  output  1  a load-use stall is active this cycle
- stall_cycles_o  output  CNT_W  cycles with pc_write_o=0, saturating
- flush_events_o  output  CNT_W  taken-branch flushes, saturating

Behaviour:
- State: fsm in {RUN, LU_STALL}; bub_cnt is 3 bits. Outputs are a Mealy function of state and inputs, so they are valid in the same cycle the hazard is presented.
- Reset (rst=1, asynchronous): fsm=RUN, bub_cnt=0, both counters=0. While rst is high, outputs are pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, hazard=0.
- lu_hit is asserted when all of the following hold:
  - id_valid_i && ex_memread_i && ex_rt_addr_i!=0, and
  - (ex_rt_addr_i==id_rs_addr_i || (id_uses_rt_i && ex_rt_addr_i==id_rt_addr_i)).
- Priority per cycle: branch_taken_i, then load-use (lu_hit in RUN, or state LU_STALL), then fetch_stall_i, then normal.
  - Branch: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1. Next fsm=RUN, bub_cnt=0; any pending stall is abandoned because its instruction is squashed.
  - Load-use: pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0, hazard=1.
  - fetch_stall_i: pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0, hazard=0.
  - Normal: pc_write=1, if_id_write=1, both flushes=0.
- RUN -> LU_STALL when lu_hit && !branch_taken_i && LOAD_BUBBLES>1; load bub_cnt=LOAD_BUBBLES-1. With LOAD_BUBBLES=1, stay in RUN: the single bubble clears ex_memread on the next cycle.
- LU_STALL: bub_cnt decrements each cycle, regardless of fetch_stall_i. When bub_cnt==1, next fsm=RUN. lu_hit is ignored while in LU_STALL.
- Counters:
  - stall_cycles increments when pc_write_o==0 and rst=0.
  - flush_events increments when branch_taken_i=1.
  - Both saturate at all-ones.
  - clr_cnt_i zeroes both and wins over an increment in the same cycle.
- Register $0 never creates a hazard.

Decomposition:
- Shared package pipe_ctrl_pkg: hz_state_t enum {RUN, LU_STALL}, REG_ZERO=5'd0, the reset-time control vector constant.
- One sub-module, sat_counter (parameter W, inputs inc and clr, async rst), instantiated twice.

Test Plan:
- Normal run, no hazards, 10 cycles -> pc_write=1, if_id_write=1, both flushes=0 every cycle; stall_cycles=0.
- lw $2 in EX (ex_memread=1, ex_rt=2), ID add with rs=2, LOAD_BUBBLES=1 -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_flush=1, hazard=1; stall_cycles=1.
- Same hazard with LOAD_BUBBLES=3, bubbles clearing ex_memread -> 3 consecutive stall cycles, then RUN; stall_cycles=3. Hazard with ex_rt=0, or rt match with id_uses_rt=0 -> no stall.
- branch_taken_i in the 2nd cycle of a 3-bubble stall -> that cycle pc_write=1, both flushes=1; next cycle normal; flush_events=1.
- fetch_stall_i held 4 cycles -> 4 cycles of pc_write=0 with id_ex_flush=1, hazard=0. Then clr_cnt_i together with a stall cycle -> counters read 0 the next cycle.
- CNT_W=4, 20 stall cycles -> stall_cycles saturates at 15. rst asserted mid-LU_STALL -> immediate flush outputs, fsm=RUN, counters 0.
